// File: rtl/div_pkg.sv
// Shared types and constants for the shift-subtract divider.
// Holds the FSM state enum, default operand width and the divide-by-zero quotient.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_WIDTH     = 16;
    localparam int DIV_MAX_WIDTH = 64;

    // Wide enough for any supported WIDTH; users slice the low bits they need.
    localparam logic [DIV_MAX_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift one dividend bit into the partial remainder
// and subtract the divisor when it fits. Purely combinational.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic           fits;

    assign shifted = {rem_i[WIDTH-1:0], bit_i};

    // A set top bit means the true shifted value exceeds any WIDTH-bit divisor.
    assign fits    = rem_i[WIDTH] | (shifted >= {1'b0, divisor_i});
    assign q_bit_o = fits;
    assign rem_o   = fits ? (shifted - {1'b0, divisor_i}) : shifted;

endmodule

// File: rtl/shift_subtract_divider.sv
// Iterative restoring divider with start/busy/done handshake, one quotient bit per clock.
// Define SHIFT_SUBTRACT_DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module shift_subtract_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] shq_q, shq_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remd_q, remd_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   step_rem;
    logic             step_bit;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quot_final;
    logic [WIDTH-1:0] rem_final;
    logic             accept;

`ifdef SHIFT_SUBTRACT_DIVIDER_SIGNED_EN
    logic dvd_neg, dvs_neg;
    logic neg_quot_q, neg_quot_d;
    logic neg_rem_q, neg_rem_d;

    assign dvd_neg = dividend[WIDTH-1];
    assign dvs_neg = divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? -dividend : dividend;
    assign dvs_mag = dvs_neg ? -divisor : divisor;
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
`endif

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .bit_i    (shq_q[WIDTH-1]),
        .divisor_i(dvsr_q),
        .rem_o    (step_rem),
        .q_bit_o  (step_bit)
    );

    assign accept = start && (state_q != CALC);

    // Results of the final step, sign-corrected when signed operation is built in.
    always_comb begin
        quot_final = {shq_q[WIDTH-2:0], step_bit};
        rem_final  = step_rem[WIDTH-1:0];
`ifdef SHIFT_SUBTRACT_DIVIDER_SIGNED_EN
        if (neg_quot_q) quot_final = -quot_final;
        if (neg_rem_q)  rem_final  = -rem_final;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        shq_d   = shq_q;
        dvsr_d  = dvsr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        remd_d  = remd_q;
        dbz_d   = dbz_q;
`ifdef SHIFT_SUBTRACT_DIVIDER_SIGNED_EN
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
`endif

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    state_d = CALC;
                    busy_d  = 1'b1;
                    dbz_d   = 1'b0;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    rem_d   = '0;
                    dvsr_d  = dvs_mag;
                    // A zero divisor keeps the raw dividend so it can be returned as the remainder.
                    shq_d   = (divisor == '0) ? dividend : dvd_mag;
`ifdef SHIFT_SUBTRACT_DIVIDER_SIGNED_EN
                    neg_quot_d = dvd_neg ^ dvs_neg;
                    neg_rem_d  = dvd_neg;
`endif
                end
            end

            CALC: begin
                if (dvsr_q == '0) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    dbz_d   = 1'b1;
                    quot_d  = DIV_ZERO_QUOTIENT[WIDTH-1:0];
                    remd_d  = shq_q;
                end else begin
                    rem_d = step_rem;
                    shq_d = {shq_q[WIDTH-2:0], step_bit};
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        quot_d  = quot_final;
                        remd_d  = rem_final;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments and a synchronous reset sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            shq_q   <= '0;
            dvsr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            remd_q  <= '0;
            dbz_q   <= 1'b0;
`ifdef SHIFT_SUBTRACT_DIVIDER_SIGNED_EN
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            shq_q   <= shq_d;
            dvsr_q  <= dvsr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
            dbz_q   <= dbz_d;
`ifdef SHIFT_SUBTRACT_DIVIDER_SIGNED_EN
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = remd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_shift_subtract_divider.sv
// Self-checking bench for shift_subtract_divider: directed cases plus random operands
// compared against an arithmetic reference model.
module tb_shift_subtract_divider;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    shift_subtract_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands as integers.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        int qi, ri;
        if (b == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
            return;
        end
        z = 1'b0;
`ifdef SHIFT_SUBTRACT_DIVIDER_SIGNED_EN
        qi = int'($signed(a)) / int'($signed(b));
        ri = int'($signed(a)) % int'($signed(b));
`else
        qi = int'(a) / int'(b);
        ri = int'(a) % int'(b);
`endif
        q = qi[W-1:0];
        r = ri[W-1:0];
    endfunction

    // Drive start at the current negedge; returns at the negedge after the accepting edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom();
        divisor  = $urandom();
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("done_after_start", {31'd0, done}, 32'd0);
    endtask

    // Wait (bounded) for done, then compare latency and results with the model.
    task automatic wait_result(input int n0, input logic [W-1:0] a, input logic [W-1:0] b,
                               input string tag);
        int n;
        logic [W-1:0] eq, er;
        logic ez;
        n = n0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        model(a, b, eq, er, ez);
        check({tag, "_latency"}, n, ez ? 32'd1 : W);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_quot"}, {16'd0, quotient}, {16'd0, eq});
        check({tag, "_rem"}, {16'd0, remainder}, {16'd0, er});
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
    endtask

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        @(negedge clk);
        launch(a, b);
        wait_result(0, a, b, tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int done_seen;
        logic [W-1:0] ra, rb;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quot", {16'd0, quotient}, 32'd0);
        check("rst_rem", {16'd0, remainder}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);

        run_div(16'd100, 16'd7, "basic");
        run_div(16'hFFFF, 16'h0001, "max_dividend");
        run_div(16'h0005, 16'h0009, "small_over_big");
        run_div(16'd1234, 16'd0, "div_zero");
        run_div(16'd7, 16'd2, "dbz_cleared");

        // Start pulsed mid-operation must be ignored.
        @(negedge clk);
        launch(16'd50, 16'd5);
        repeat (8) @(negedge clk);
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 16'd3;
        @(negedge clk);
        start = 1'b0;
        wait_result(9, 16'd50, 16'd5, "ignored_start");

        // Start issued during the DONE cycle is accepted immediately.
        launch(16'd999, 16'd10);
        wait_result(0, 16'd999, 16'd10, "back_to_back");
        @(negedge clk);

        // Reset mid-operation aborts without a done pulse.
        launch(16'd1000, 16'd3);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_quot", {16'd0, quotient}, 32'd0);
        check("abort_rem", {16'd0, remainder}, 32'd0);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 32'd0);
        run_div(16'd1000, 16'd3, "after_abort");

`ifdef SHIFT_SUBTRACT_DIVIDER_SIGNED_EN
        run_div(16'hFF9C, 16'd7, "signed_neg_dvd");
        run_div(16'd100, 16'hFFF9, "signed_neg_dvs");
        run_div(16'h8000, 16'hFFFF, "signed_min_by_m1");
`endif

        for (int i = 0; i < 30; i++) begin
            ra = $urandom();
            case ($urandom_range(0, 3))
                0: rb = '0;
                1: rb = W'($urandom_range(1, 15));
                default: rb = $urandom();
            endcase
            run_div(ra, rb, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_subtract_divider.md
Name: shift_subtract_divider

Overview:
- Iterative restoring divider, the inverse of the team's shift-add multiplier.
- Produces one quotient bit per clock by shifting the partial remainder left and conditionally subtracting the divisor.
- Sits beside the multiplier in the arithmetic datapath.
- Uses a start/busy/done handshake so a controller can launch one division and later collect quotient and remainder.

Parameters:
- WIDTH, 16, width of dividend, divisor, quotient and remainder in bits.
- CNT_W, $clog2(WIDTH), width of the iteration counter (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- start  input  1  request a division; accepted only when busy=0.
- dividend  input  WIDTH  numerator, sampled at the accepted start.
- divisor  input  WIDTH  denominator, sampled at the accepted start.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse: results valid.
- quotient  output  WIDTH  result quotient, held until the next accepted start.
- remainder  output  WIDTH  result remainder, held until the next accepted start.
- div_by_zero  output  1  set with done when the sampled divisor is 0; held with the results.

Behaviour:
- Reset: rst_n=0 at a rising edge clears the following, regardless of state:
  - state goes to IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - counter and working registers cleared.
  - Reset mid-operation aborts the division; no done pulse is produced.
- States: IDLE, CALC, DONE. Encoding is an enum from the package.
- Accept: start=1 with state IDLE or DONE at edge k.
  - Latch dividend into the quotient shift register and divisor into its register.
  - Clear the WIDTH+1-bit partial remainder; counter=WIDTH-1.
  - Go to CALC with busy=1 from edge k.
- start while busy=1 is ignored; the latched operands are unaffected.
- CALC, one step per edge:
  - t = {rem[WIDTH-1:0], q[WIDTH-1]}.
  - If t >= {1'b0,divisor}: rem = t - divisor, q = {q[WIDTH-2:0],1}.
  - Else: rem = t, q = {q[WIDTH-2:0],0}.
  - Counter decrements; when counter==0, the step is performed and the state moves to DONE.
- Latency: WIDTH steps occupy edges k+1..k+WIDTH.
  - At edge k+WIDTH: quotient/remainder outputs loaded, done=1, busy=0.
  - With WIDTH=16, done rises 16 cycles after the start edge.
- DONE: lasts exactly one cycle (done=1), then IDLE.
  - A start during DONE is accepted; done falls and busy rises at that same edge.
- Divide by zero: divisor==0 at accept skips CALC.
  - At edge k+1: state DONE, done=1, div_by_zero=1.
  - quotient = all ones, remainder = dividend.
  - busy is high for one cycle only.
- div_by_zero clears at the next accepted start.
- Unsigned arithmetic by default. Invariant: dividend == quotient*divisor + remainder, with remainder < divisor.
- Outputs are registered only; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SHIFT_SUBTRACT_DIVIDER_SIGNED_EN.
- Defined: operands are two's complement.
  - Magnitudes are taken at accept and the same unsigned core runs.
  - The quotient is negated when the operand signs differ (truncation toward zero).
  - The remainder takes the sign of the dividend.
  - Sign fix-up happens in the DONE-loading edge; latency is unchanged.
  - Divide by zero still returns quotient all ones and remainder = dividend.
  - Most-negative / -1 returns quotient = most-negative, remainder 0, no flag.
- Undefined: purely unsigned; no sign logic is synthesized.

Decomposition:
- Package div_pkg contains:
  - the state enum typedef (IDLE, CALC, DONE).
  - constant DIV_ZERO_QUOTIENT (all ones).
  - default DIV_WIDTH=16.
- One natural sub-module, div_step: combinational single restoring step.
  - Inputs: partial remainder, incoming bit, divisor.
  - Outputs: next remainder, quotient bit.
  - Instantiated once and reused each cycle.

Test Plan:
- Basic division: dividend=100, divisor=7, start one cycle -> busy for 16 cycles; done pulse at start edge+16; quotient=14, remainder=2.
- Maximum dividend: 0xFFFF / 0x0001 -> quotient=0xFFFF, remainder=0; then 0x0005 / 0x0009 -> quotient=0, remainder=5.
- Divide by zero: 1234 / 0 -> done one cycle after start; div_by_zero=1, quotient=0xFFFF, remainder=1234; next valid start clears the flag.
- Start while busy: start 50/5, pulse start with 9/3 eight cycles later -> ignored; result quotient=10, remainder=0. Back-to-back start during the DONE cycle is accepted and the second result is correct.
- Reset mid-operation: start 1000/3, assert rst_n=0 at cycle 6 -> all outputs 0 at the next edge, no done; a fresh 1000/3 then gives quotient=333, remainder=1.
- Signed, with SHIFT_SUBTRACT_DIVIDER_SIGNED_EN:
  - -100/7 -> quotient=0xFFF2 (-14), remainder=0xFFFE (-2).
  - 100/-7 -> quotient=0xFFF2, remainder=2.
